upscale_pipe: RTL
=================

# upscale_pipe

Pipelined, parametrised replacement for the fixed divide-by-4 pixel-coordinate scaler in the video output path. It maps HDMI raster counters (hcount/vcount) to frame-buffer coordinates and a linear frame-buffer read address, with a runtime-selectable power-of-two scale factor and pan offsets. Configuration changes are applied only at frame boundaries, so a frame never tears. Sync and blank are delayed to stay aligned with the address. The block sits between the video timing generator and the frame-buffer BRAM read port.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- FB_WIDTH, 320, frame-buffer width in pixels
- FB_HEIGHT, 180, frame-buffer height in lines
- MAX_SHIFT, 3, largest allowed log2 scale factor
- RESET_SHIFT, 2, active shift after reset

Ports (one clock; reset is synchronous and active-high):
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- hcount_in  input  11  raster x
- vcount_in  input  10  raster y
- hsync_in, vsync_in, blank_in  input  1 each  timing-generator controls
- new_frame_in  input  1  single-cycle frame-boundary strobe
- shift_req_in  input  2  requested log2 scale factor
- off_x_in  input  11  requested horizontal pan, in frame-buffer pixels
- off_y_in  input  10  requested vertical pan, in frame-buffer lines
- fb_x_out  output  11  frame-buffer x
- fb_y_out  output  10  frame-buffer y
- fb_addr_out  output  $clog2(FB_WIDTH*FB_HEIGHT)  linear read address
- valid_addr_out  output  1  coordinates and address are in range
- hsync_out, vsync_out, blank_out  output  1 each  delayed controls
- shift_active_out  output  2  shift currently in use

## Operation
- Shadow config: shift_req_in, off_x_in and off_y_in are sampled on any cycle with new_frame_in=1. All other cycles hold the active config.
- Shift clamp: a shift_req_in value greater than MAX_SHIFT is stored as MAX_SHIFT.
- Config timing: a sample presented on the same cycle as new_frame_in uses the old config. The new config applies from the next input sample.
- Stage 1:
  - in_win = hcount_in < H_ACTIVE && vcount_in < V_ACTIVE.
  - x = (hcount_in >> shift) + off_x.
  - y = (vcount_in >> shift) + off_y.
  - Sums are computed one bit wider than the inputs; there is no wrap-around.
- Stage 2:
  - ok = in_win && x < FB_WIDTH && y < FB_HEIGHT.
  - Compute row = y * FB_WIDTH.
- Stage 3:
  - addr = row + x.
  - If ok=0, force fb_addr_out, fb_x_out and fb_y_out to 0 and valid_addr_out to 0.
- Sync path: hsync, vsync and blank pass through a 3-deep shift register with no modification.
- Reset (applies whenever rst_in=1, including mid-frame):
  - all pipeline registers and outputs go to 0;
  - the active config becomes shift=RESET_SHIFT, off_x=0, off_y=0;
  - shift_active_out = RESET_SHIFT.

## Timing
- Latency is exactly 3 cycles from every input sample to all matching outputs; throughput is one sample per cycle. There is no stall and no handshake.
- shift_active_out updates the cycle after the new_frame_in strobe.
- After rst_in is deasserted, outputs stay 0 for 3 cycles, then track inputs. Reset asserted mid-frame flushes the pipeline; there are no partial results.
- Simultaneous rst_in and new_frame_in: reset wins.

## Structure
- upscale_pkg holds:
  - constants H_ACTIVE_DEF, V_ACTIVE_DEF, FB_WIDTH_DEF, FB_HEIGHT_DEF;
  - localparam-style width helpers;
  - typedef struct upscale_cfg_t {shift, off_x, off_y}.
- Sub-module pipe_delay #(WIDTH, DEPTH) carries the 3-bit sync/blank bus. It is reusable elsewhere in the video path.
- The multiply by the FB_WIDTH constant is inferred. No DSP instantiation.

## Test plan
- Reset config, hcount=1279, vcount=719 -> 3 cycles later: fb_x=319, fb_y=179, fb_addr=57599, valid=1.
- hcount=1280, vcount=0 -> valid_addr_out=0, fb_addr_out=0 after 3 cycles. Sync and blank are delayed exactly 3 cycles.
- shift_req_in=1 applied mid-frame without a strobe -> no change. After a new_frame_in strobe, hcount=100, vcount=50 -> fb_x=50, fb_y=25, fb_addr=8050.
- Strobe with shift_req_in=3 and off_x=200, then hcount=1279 -> 159+200=359 ≥ 320, so valid=0. hcount=800 -> fb_x=300, valid=1.
- Strobe with shift_req_in=3 while MAX_SHIFT=2 (override) -> shift_active_out=2.
- rst_in asserted for 1 cycle mid-stream -> next 3 output cycles are all 0. Then shift_active_out=RESET_SHIFT and normal mapping resumes.

Source files
------------

// File: rtl/upscale_pkg.sv
// Shared constants, widths and config record for the raster-to-frame-buffer scaler.
package upscale_pkg;

  localparam int H_ACTIVE_DEF  = 1280;
  localparam int V_ACTIVE_DEF  = 720;
  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 180;

  localparam int HC_W    = 11;
  localparam int VC_W    = 10;
  localparam int SHIFT_W = 2;
  // Sums are one bit wider than the raster counters so a large pan never wraps
  // back into the valid range.
  localparam int X_SUM_W = HC_W + 1;
  localparam int Y_SUM_W = VC_W + 1;

  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic [HC_W-1:0]    off_x;
    logic [VC_W-1:0]    off_y;
  } upscale_cfg_t;

  // Requests above the supported maximum saturate rather than alias.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] req,
                                                     input int max_shift);
    if (int'(req) > max_shift) return SHIFT_W'(max_shift);
    return req;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with synchronous clear.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift the bus one stage per clock; reset flushes every stage.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_in;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign d_out = stage_q[DEPTH-1];

endmodule

// File: rtl/upscale_pipe.sv
// Three-stage raster-to-frame-buffer coordinate and address mapper with
// frame-synchronous scale/pan configuration.
module upscale_pipe
  import upscale_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int FB_WIDTH    = FB_WIDTH_DEF,
  parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter int MAX_SHIFT   = 3,
  parameter int RESET_SHIFT = 2
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [10:0]                            hcount_in,
  input  logic [9:0]                             vcount_in,
  input  logic                                   hsync_in,
  input  logic                                   vsync_in,
  input  logic                                   blank_in,
  input  logic                                   new_frame_in,
  input  logic [1:0]                             shift_req_in,
  input  logic [10:0]                            off_x_in,
  input  logic [9:0]                             off_y_in,
  output logic [10:0]                            fb_x_out,
  output logic [9:0]                             fb_y_out,
  output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  fb_addr_out,
  output logic                                   valid_addr_out,
  output logic                                   hsync_out,
  output logic                                   vsync_out,
  output logic                                   blank_out,
  output logic [1:0]                             shift_active_out
);

  localparam int ADDR_W = $clog2(FB_WIDTH*FB_HEIGHT);

  upscale_cfg_t         cfg_d, cfg_q;
  logic [X_SUM_W-1:0]   x1_d, x1_q;
  logic [Y_SUM_W-1:0]   y1_d, y1_q;
  logic                 win1_d, win1_q;
  logic                 ok2_d, ok2_q;
  logic [ADDR_W-1:0]    row2_d, row2_q;
  logic [HC_W-1:0]      x2_d, x2_q;
  logic [VC_W-1:0]      y2_d, y2_q;
  logic [HC_W-1:0]      x3_d, x3_q;
  logic [VC_W-1:0]      y3_d, y3_q;
  logic [ADDR_W-1:0]    addr3_d, addr3_q;
  logic                 ok3_d, ok3_q;
  logic [2:0]           sync_out;

  // Next-state for the shadow config and all three datapath stages. Stage 1
  // uses cfg_q, so a sample coincident with the strobe still sees the old frame's config.
  always_comb begin
    cfg_d = cfg_q;
    if (new_frame_in) begin
      cfg_d.shift = clamp_shift(shift_req_in, MAX_SHIFT);
      cfg_d.off_x = off_x_in;
      cfg_d.off_y = off_y_in;
    end

    win1_d = (int'(hcount_in) < H_ACTIVE) && (int'(vcount_in) < V_ACTIVE);
    x1_d   = X_SUM_W'(hcount_in >> cfg_q.shift) + X_SUM_W'(cfg_q.off_x);
    y1_d   = Y_SUM_W'(vcount_in >> cfg_q.shift) + Y_SUM_W'(cfg_q.off_y);

    ok2_d  = win1_q && (int'(x1_q) < FB_WIDTH) && (int'(y1_q) < FB_HEIGHT);
    // Truncation is harmless: row and x are only used when ok2 proves them in range.
    row2_d = ADDR_W'(int'(y1_q) * FB_WIDTH);
    x2_d   = x1_q[HC_W-1:0];
    y2_d   = y1_q[VC_W-1:0];

    ok3_d   = ok2_q;
    addr3_d = ok2_q ? (row2_q + ADDR_W'(x2_q)) : '0;
    x3_d    = ok2_q ? x2_q : '0;
    y3_d    = ok2_q ? y2_q : '0;
  end

  // Register config and pipeline; reset flushes every stage and restores the default config.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cfg_q.shift <= SHIFT_W'(RESET_SHIFT);
      cfg_q.off_x <= '0;
      cfg_q.off_y <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      win1_q  <= 1'b0;
      ok2_q   <= 1'b0;
      row2_q  <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      x3_q    <= '0;
      y3_q    <= '0;
      addr3_q <= '0;
      ok3_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      win1_q  <= win1_d;
      ok2_q   <= ok2_d;
      row2_q  <= row2_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      addr3_q <= addr3_d;
      ok3_q   <= ok3_d;
    end
  end

  pipe_delay #(.WIDTH(3), .DEPTH(3)) u_sync_dly (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   ({hsync_in, vsync_in, blank_in}),
    .d_out  (sync_out)
  );

  assign {hsync_out, vsync_out, blank_out} = sync_out;
  assign fb_x_out         = x3_q;
  assign fb_y_out         = y3_q;
  assign fb_addr_out      = addr3_q;
  assign valid_addr_out   = ok3_q;
  assign shift_active_out = cfg_q.shift;

endmodule
